// File: rtl/load_fwd_unit_pkg.sv
// Shared widths and FSM state encoding for the load forwarding unit.
package load_fwd_unit_pkg;

    localparam int DATA_LEN    = 32;
    localparam int ADDR_LEN    = 32;
    localparam int SPECTAG_LEN = 5;
    localparam int RRF_SEL     = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_RESP    = 2'd3
    } ld_state_e;

endpackage

// File: rtl/load_fwd_unit_spec_ctrl.sv
// Speculation bookkeeping for the in-flight load: holds specbit/spectag,
// flags a mispredict that kills the held load or an incoming request.
module ld_spec_ctrl #(
    parameter int SPECTAG_LEN = load_fwd_unit_pkg::SPECTAG_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture,
    input  logic                   req_specbit,
    input  logic [SPECTAG_LEN-1:0] req_spectag,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] prtag,
    input  logic [SPECTAG_LEN-1:0] spectagfix,
    output logic                   kill,
    output logic                   req_kill
);

    logic                   specbit_q;
    logic [SPECTAG_LEN-1:0] spectag_q;
    logic                   held_clear;
    logic                   req_clear;

    // Kill checks for the held load and for a request arriving this cycle
    assign kill     = prmiss & specbit_q   & (|(spectagfix & spectag_q));
    assign req_kill = prmiss & req_specbit & (|(spectagfix & req_spectag));

    // A resolved branch that does not kill the load makes it non-speculative
    assign held_clear = prmiss | (prsuccess & (prtag == spectag_q));
    assign req_clear  = prmiss | (prsuccess & (prtag == req_spectag));

    // Speculation state capture and clearing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            specbit_q <= 1'b0;
            spectag_q <= '0;
        end else if (capture) begin
            specbit_q <= req_specbit & ~req_clear;
            spectag_q <= req_spectag;
        end else if (held_clear) begin
            specbit_q <= 1'b0;
        end
    end

endmodule

// File: rtl/load_fwd_unit.sv
// Single-outstanding load unit: store-buffer forwarding lookup, dmem read on
// miss, valid/ready writeback, squash on branch mispredict.
module load_fwd_unit
    import load_fwd_unit_pkg::*;
#(
    parameter int DATA_LEN    = load_fwd_unit_pkg::DATA_LEN,
    parameter int ADDR_LEN    = load_fwd_unit_pkg::ADDR_LEN,
    parameter int SPECTAG_LEN = load_fwd_unit_pkg::SPECTAG_LEN,
    parameter int RRF_SEL     = load_fwd_unit_pkg::RRF_SEL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [ADDR_LEN-1:0]    ld_addr,
    input  logic [RRF_SEL-1:0]     ld_rrftag,
    input  logic                   ld_specbit,
    input  logic [SPECTAG_LEN-1:0] ld_spectag,
    input  logic                   prsuccess,
    input  logic                   prmiss,
    input  logic [SPECTAG_LEN-1:0] prtag,
    input  logic [SPECTAG_LEN-1:0] spectagfix,
    output logic [ADDR_LEN-1:0]    sb_ldaddr,
    input  logic                   sb_hit,
    input  logic [DATA_LEN-1:0]    sb_lddata,
    output logic                   memoccupy_ld,
    output logic [ADDR_LEN-1:0]    dmem_raddr,
    input  logic [DATA_LEN-1:0]    dmem_rdata,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [DATA_LEN-1:0]    wb_data,
    output logic [RRF_SEL-1:0]     wb_rrftag
);

    ld_state_e             state_q;
    logic [ADDR_LEN-1:0]   addr_q;
    logic [RRF_SEL-1:0]    rrftag_q;
    logic [DATA_LEN-1:0]   data_q;
    logic                  kill;
    logic                  req_kill;
    logic                  capture;

    assign capture = (state_q == ST_IDLE) & ld_valid & ~req_kill;

    ld_spec_ctrl #(
        .SPECTAG_LEN(SPECTAG_LEN)
    ) u_spec_ctrl (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .req_specbit(ld_specbit),
        .req_spectag(ld_spectag),
        .prmiss     (prmiss),
        .prsuccess  (prsuccess),
        .prtag      (prtag),
        .spectagfix (spectagfix),
        .kill       (kill),
        .req_kill   (req_kill)
    );

    // Load FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rrftag_q <= '0;
            data_q   <= '0;
        end else if ((state_q != ST_IDLE) && kill) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        addr_q   <= ld_addr;
                        rrftag_q <= ld_rrftag;
                        state_q  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (sb_hit) begin
                        data_q  <= sb_lddata;
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_MEMWAIT;
                    end
                end
                ST_MEMWAIT: begin
                    data_q  <= dmem_rdata;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (wb_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ld_ready     = (state_q == ST_IDLE);
    assign memoccupy_ld = (state_q == ST_LOOKUP);
    assign sb_ldaddr    = addr_q;
    assign dmem_raddr   = addr_q;
    // A load killed in RESP must not transfer in the kill cycle
    assign wb_valid     = (state_q == ST_RESP) & ~kill;
    assign wb_data      = data_q;
    assign wb_rrftag    = rrftag_q;

endmodule
